// File: rtl/phased_burst_generator_pkg.sv
// Shared sizing constants and FSM encoding for the phased burst generator.
package phased_burst_generator_pkg;
  localparam int NUM_CH   = 37;
  localparam int TONE_DIV = 600;
  localparam int DELAY_W  = 10;
  localparam int CYCLES_W = 8;
  localparam int ADDR_W   = 6;
  localparam int PHASE_W  = $clog2(TONE_DIV);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(TONE_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(TONE_DIV / 2);
  // Tick counter parks one past the largest delay so no channel can re-arm.
  localparam logic [DELAY_W:0]   T_SAT      = {1'b1, {DELAY_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/phased_burst_generator_if.sv
// Control/status bundle between the sequencer (master) and the generator (slave).
interface phased_burst_generator_if;
  import phased_burst_generator_pkg::*;

  // No ready/valid pairs: delay_wr_en, start and stop are single-cycle strobes
  // sampled on every clk24 edge; done is a single-cycle pulse, busy a level.
  logic                delay_wr_en;
  logic [ADDR_W-1:0]   delay_wr_addr;
  logic [DELAY_W-1:0]  delay_wr_data;
  logic                start;
  logic                stop;
  logic [CYCLES_W-1:0] burst_cycles;
  logic                busy;
  logic                done;
  logic [NUM_CH-1:0]   speakers;
  state_e              dbg_state;

  modport master (
    output delay_wr_en, delay_wr_addr, delay_wr_data, start, stop, burst_cycles,
    input  busy, done, speakers, dbg_state
  );

  modport slave (
    input  delay_wr_en, delay_wr_addr, delay_wr_data, start, stop, burst_cycles,
    output busy, done, speakers, dbg_state
  );
endinterface

// File: rtl/phased_burst_generator_channel.sv
// One speaker channel: arms when the shared tick count hits its delay, then
// plays burst_cycles square-wave periods and reports completion.
module phased_burst_generator_channel
  import phased_burst_generator_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run_i,
  input  logic                clear_i,
  input  logic [DELAY_W:0]    t_i,
  input  logic [DELAY_W-1:0]  delay_i,
  input  logic [CYCLES_W-1:0] cycles_i,
  output logic                out_o,
  output logic                fin_next_o
);
  logic                armed_q, armed_d;
  logic                fin_q, fin_d;
  logic                out_q, out_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [CYCLES_W-1:0] period_q, period_d;

  always_comb begin
    armed_d  = armed_q;
    fin_d    = fin_q;
    out_d    = out_q;
    phase_d  = phase_q;
    period_d = period_q;
    if (clear_i) begin
      armed_d  = 1'b0;
      fin_d    = 1'b0;
      out_d    = 1'b0;
      phase_d  = '0;
      period_d = '0;
    end else if (run_i) begin
      if (!armed_q) begin
        if (t_i == {1'b0, delay_i}) begin
          armed_d = 1'b1;
          out_d   = 1'b1;
        end
      end else if (!fin_q) begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (period_q == cycles_i - CYCLES_W'(1)) begin
            fin_d = 1'b1;
            out_d = 1'b0;
          end else begin
            period_d = period_q + CYCLES_W'(1);
            out_d    = 1'b1;
          end
        end else begin
          phase_d = phase_q + PHASE_W'(1);
          out_d   = (phase_d < PHASE_HALF);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q  <= 1'b0;
      fin_q    <= 1'b0;
      out_q    <= 1'b0;
      phase_q  <= '0;
      period_q <= '0;
    end else begin
      armed_q  <= armed_d;
      fin_q    <= fin_d;
      out_q    <= out_d;
      phase_q  <= phase_d;
      period_q <= period_d;
    end
  end

  assign out_o      = out_q;
  // Next-state view lets the FSM leave RUN on the same edge the last channel ends.
  assign fin_next_o = fin_d;
endmodule

// File: rtl/phased_burst_generator.sv
// Beam-steered burst generator: delay table, shared tick counter, burst FSM
// and one channel instance per speaker pin.
module phased_burst_generator
  import phased_burst_generator_pkg::*;
(
  input logic clk24,
  input logic reset,
  phased_burst_generator_if.slave bus
);
  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  delay_q [NUM_CH];
  logic [DELAY_W:0]    t_q, t_d;
  logic [CYCLES_W-1:0] cyc_q, cyc_d;
  logic [NUM_CH-1:0]   spk;
  logic [NUM_CH-1:0]   fin_next;
  logic                run;
  logic                clear;

  // Table only changes in IDLE, so it is frozen for the whole burst.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) delay_q[i] <= '0;
    end else if (bus.delay_wr_en && (state_q == ST_IDLE) &&
                 (bus.delay_wr_addr < ADDR_W'(NUM_CH))) begin
      delay_q[bus.delay_wr_addr] <= bus.delay_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    cyc_d   = cyc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.burst_cycles != '0) begin
            state_d = ST_RUN;
            cyc_d   = bus.burst_cycles;
            t_d     = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (t_q != T_SAT) t_d = t_q + (DELAY_W+1)'(1);
        if (bus.stop || (&fin_next)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cyc_q   <= cyc_d;
    end
  end

  assign run   = (state_q == ST_RUN);
  assign clear = !run || bus.stop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    phased_burst_generator_channel u_ch (
      .clk        (clk24),
      .rst        (reset),
      .run_i      (run),
      .clear_i    (clear),
      .t_i        (t_q),
      .delay_i    (delay_q[i]),
      .cycles_i   (cyc_q),
      .out_o      (spk[i]),
      .fin_next_o (fin_next[i])
    );
  end

  assign bus.speakers  = spk;
  assign bus.busy      = run;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.dbg_state = state_q;
endmodule
